video_chunk_requester: RTL and testbench

Downstream neighbour of the video generator source stage. It walks one scanline per start command, pushes chunk requests {vPos, chunkNum} into the request FIFO, then drains the RGB565 response FIFO into a line buffer write port. The number of chunks in flight is credit-limited, so the response FIFO can never overflow. Sits between the scaler line sequencer and the scaler line buffer RAM, in the scalerClock domain.

---
 rtl/video_chunk_requester.sv | 144 ++++++++++++++
 tb/tb_video_chunk_requester.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_chunk_requester.sv
// Video chunk requester.
// For each accepted startLine it walks one scanline. It issues {line, chunk}
// requests into the request FIFO, limited by credits. It then drains the
// RGB565 response FIFO into the line buffer write port, one pixel per cycle.
module video_chunk_requester #(
    parameter int CHUNK_BITS      = 5,
    parameter int HACTIVE_BITS    = 11,
    parameter int VACTIVE_BITS    = 11,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                           scalerClock,
    input  logic                                           reset,
    input  logic                                           startLine,
    input  logic [VACTIVE_BITS-1:0]                        lineNumber,
    input  logic [HACTIVE_BITS-CHUNK_BITS:0]               chunkCount,
    output logic                                           busy,
    output logic                                           lineDone,
    output logic                                           requestFifoWriteEnable,
    input  logic                                           requestFifoFull,
    output logic [VACTIVE_BITS+HACTIVE_BITS-CHUNK_BITS-1:0] requestFifoWriteData,
    output logic                                           responseFifoReadEnable,
    input  logic                                           responseFifoEmpty,
    input  logic [15:0]                                    responseFifoReadData,
    output logic                                           lineBufferWriteEnable,
    output logic [HACTIVE_BITS-1:0]                        lineBufferWriteAddress,
    output logic [15:0]                                    lineBufferWriteData
);
    localparam int CNT_W = HACTIVE_BITS - CHUNK_BITS + 1;
    localparam int PIX_W = HACTIVE_BITS + 1;
    localparam int OUT_W = 3;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic [VACTIVE_BITS-1:0] line_q, line_d;
    logic [CNT_W-1:0]        chunk_count_q, chunk_count_d;
    logic [CNT_W-1:0]        req_index_q, req_index_d;
    logic [OUT_W-1:0]        outstanding_q, outstanding_d;
    logic [PIX_W-1:0]        popped_q, popped_d;
    logic [PIX_W-1:0]        pixel_index_q, pixel_index_d;
    logic                    wr_pending_q, wr_pending_d;
    logic                    zero_done_q, zero_done_d;

    logic [PIX_W-1:0]        total_pixels;
    logic                    start_accept;
    logic                    push;
    logic                    pop;
    logic                    credit;
    logic                    last_write;

    // Per-cycle qualifiers: these are derived from registered state and the live FIFO flags
    always_comb begin
        total_pixels = {chunk_count_q, {CHUNK_BITS{1'b0}}};
        start_accept = (state_q == ST_IDLE) && startLine && (chunkCount != '0);
        push         = (state_q == ST_ACTIVE) && (req_index_q < chunk_count_q) &&
                       !requestFifoFull && (outstanding_q < MAX_OUT);
        pop          = (state_q == ST_ACTIVE) && !responseFifoEmpty &&
                       (popped_q < total_pixels);
        credit       = wr_pending_q && (&pixel_index_q[CHUNK_BITS-1:0]);
        last_write   = wr_pending_q && (pixel_index_q == total_pixels - PIX_W'(1));
    end

    // State register
    always_ff @(posedge scalerClock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: a line runs until its final pixel is written
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_accept) state_d = ST_ACTIVE;
            ST_ACTIVE: if (last_write)   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: FIFO strobes follow the qualifiers; write data is masked outside write cycles
    always_comb begin
        busy                   = (state_q == ST_ACTIVE);
        lineDone               = zero_done_q || last_write;
        requestFifoWriteEnable = push;
        requestFifoWriteData   = {line_q, req_index_q[CNT_W-2:0]};
        responseFifoReadEnable = pop;
        lineBufferWriteEnable  = wr_pending_q;
        lineBufferWriteAddress = pixel_index_q[HACTIVE_BITS-1:0];
        lineBufferWriteData    = wr_pending_q ? responseFifoReadData : '0;
    end

    // Counter and latch updates for line setup, request issue, pixel drain and credits
    always_comb begin
        line_d        = line_q;
        chunk_count_d = chunk_count_q;
        req_index_d   = req_index_q;
        outstanding_d = outstanding_q;
        popped_d      = popped_q;
        pixel_index_d = pixel_index_q;
        wr_pending_d  = pop;
        zero_done_d   = (state_q == ST_IDLE) && startLine && (chunkCount == '0);
        if (start_accept) begin
            line_d        = lineNumber;
            chunk_count_d = chunkCount;
            req_index_d   = '0;
            outstanding_d = '0;
            popped_d      = '0;
            pixel_index_d = '0;
        end else if (state_q == ST_ACTIVE) begin
            if (push)         req_index_d   = req_index_q + CNT_W'(1);
            if (pop)          popped_d      = popped_q + PIX_W'(1);
            if (wr_pending_q) pixel_index_d = pixel_index_q + PIX_W'(1);
            case ({push, credit})
                2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
                2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge scalerClock) begin
        if (reset) begin
            line_q        <= '0;
            chunk_count_q <= '0;
            req_index_q   <= '0;
            outstanding_q <= '0;
            popped_q      <= '0;
            pixel_index_q <= '0;
            wr_pending_q  <= 1'b0;
            zero_done_q   <= 1'b0;
        end else begin
            line_q        <= line_d;
            chunk_count_q <= chunk_count_d;
            req_index_q   <= req_index_d;
            outstanding_q <= outstanding_d;
            popped_q      <= popped_d;
            pixel_index_q <= pixel_index_d;
            wr_pending_q  <= wr_pending_d;
            zero_done_q   <= zero_done_d;
        end
    end

endmodule

// File: tb/tb_video_chunk_requester.sv
// Testbench for video_chunk_requester.
// It models both FIFOs and the memory responder. Chunk c of any line returns
// the pixels (c*32+i) ^ salt. Every request and every line buffer write is
// checked against the expected scanline walk.
module tb_video_chunk_requester;
    localparam int CB   = 5;
    localparam int HB   = 11;
    localparam int VB   = 11;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, startLine;
    logic [VB-1:0]     lineNumber;
    logic [HB-CB:0]    chunkCount;
    logic              busy, lineDone;
    logic              requestFifoWriteEnable, requestFifoFull;
    logic [VB+HB-CB-1:0] requestFifoWriteData;
    logic              responseFifoReadEnable, responseFifoEmpty;
    logic [15:0]       responseFifoReadData;
    logic              lineBufferWriteEnable;
    logic [HB-1:0]     lineBufferWriteAddress;
    logic [15:0]       lineBufferWriteData;

    video_chunk_requester #(
        .CHUNK_BITS(CB), .HACTIVE_BITS(HB), .VACTIVE_BITS(VB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .scalerClock(clk), .reset(reset), .startLine(startLine),
        .lineNumber(lineNumber), .chunkCount(chunkCount),
        .busy(busy), .lineDone(lineDone),
        .requestFifoWriteEnable(requestFifoWriteEnable), .requestFifoFull(requestFifoFull),
        .requestFifoWriteData(requestFifoWriteData),
        .responseFifoReadEnable(responseFifoReadEnable), .responseFifoEmpty(responseFifoEmpty),
        .responseFifoReadData(responseFifoReadData),
        .lineBufferWriteEnable(lineBufferWriteEnable),
        .lineBufferWriteAddress(lineBufferWriteAddress),
        .lineBufferWriteData(lineBufferWriteData)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_done"},   32'(lineDone), 0);
        check({tag, "_rq_we"},  32'(requestFifoWriteEnable), 0);
        check({tag, "_rq_wd"},  32'(requestFifoWriteData), 0);
        check({tag, "_rs_re"},  32'(responseFifoReadEnable), 0);
        check({tag, "_lb_we"},  32'(lineBufferWriteEnable), 0);
        check({tag, "_lb_wa"},  32'(lineBufferWriteAddress), 0);
        check({tag, "_lb_wd"},  32'(lineBufferWriteData), 0);
    endtask

    // Reference model state, tracked from observed bus events
    int          cyc = 0, reqs_seen = 0, writes_seen = 0, done_cnt = 0;
    int          cur_line = 0, cur_count = 0, req3_cyc = -1, w32_cyc = -1;
    logic [HB-1:0] done_addr = '0;
    logic [16:0] first_req = '0;
    logic [15:0] salt = '0;
    bit          hold_empty = 0, hold_full = 0, toggle_empty = 0, rnd_empty = 0, rnd_full = 0;
    bit          toggle_ph = 0;
    logic [15:0] resp_q[$];

    // Environment: sample at negedge, act on FIFOs at posedge, drive flags #1 later
    initial begin : env
        logic s_rst, s_push, s_pop, s_wr, s_done, s_start, s_busy, s_full;
        logic [16:0] s_wdata;
        logic [HB-1:0] s_addr;
        logic [15:0] s_data, rd_next;
        int c;
        responseFifoEmpty = 1'b1;
        requestFifoFull = 1'b0;
        responseFifoReadData = '0;
        rd_next = '0;
        forever begin
            @(negedge clk);
            cyc++;
            s_rst = reset; s_push = requestFifoWriteEnable; s_pop = responseFifoReadEnable;
            s_wr = lineBufferWriteEnable; s_done = lineDone; s_start = startLine;
            s_busy = busy; s_full = requestFifoFull; s_wdata = requestFifoWriteData;
            s_addr = lineBufferWriteAddress; s_data = lineBufferWriteData;
            if (s_rst === 1'b0) begin
                if (s_push === 1'b1) begin
                    check("req_data", 32'(s_wdata), 32'({11'(cur_line), 6'(reqs_seen)}));
                    check("req_while_full", 32'(s_full), 0);
                    check("req_in_range", 32'(reqs_seen < cur_count), 1);
                    check("credit_limit", 32'((reqs_seen - writes_seen / 32) < MAXO), 1);
                    if (reqs_seen == 0) first_req = s_wdata;
                    reqs_seen++;
                    if (reqs_seen == 3) req3_cyc = cyc;
                end
                if (s_wr === 1'b1) begin
                    check("wr_in_range", 32'(writes_seen < cur_count * 32), 1);
                    check("wr_addr", 32'(s_addr), 32'(writes_seen));
                    check("wr_data", 32'(s_data), 32'(16'(writes_seen) ^ salt));
                    check("wr_done", 32'(s_done), 32'(writes_seen == cur_count * 32 - 1));
                    if (s_done === 1'b1) begin
                        done_cnt++;
                        done_addr = s_addr;
                    end
                    writes_seen++;
                    if (writes_seen == 32) w32_cyc = cyc;
                end else if (s_done === 1'b1) begin
                    check("empty_line_done", 32'(cur_count), 0);
                    done_cnt++;
                end
                if (s_start === 1'b1 && s_busy === 1'b0) begin
                    cur_line = int'(lineNumber);
                    cur_count = int'(chunkCount);
                    reqs_seen = 0; writes_seen = 0; req3_cyc = -1; w32_cyc = -1;
                end
            end
            @(posedge clk);
            if (s_rst !== 1'b0) begin
                resp_q.delete();
            end else begin
                if (s_push === 1'b1) begin
                    c = int'(s_wdata[5:0]);
                    for (int i = 0; i < 32; i++) resp_q.push_back(16'(c * 32 + i) ^ salt);
                end
                if (s_pop === 1'b1) rd_next = (resp_q.size() > 0) ? resp_q.pop_front() : 16'hDEAD;
            end
            #1;
            responseFifoReadData = rd_next;
            toggle_ph = ~toggle_ph;
            responseFifoEmpty = (resp_q.size() == 0) || hold_empty || (toggle_empty && toggle_ph) ||
                                (rnd_empty && ($urandom_range(0, 3) == 0));
            requestFifoFull = hold_full || (rnd_full && ($urandom_range(0, 2) == 0));
        end
    end

    task automatic start_line(input int ln, input int cnt);
        @(posedge clk); #1;
        lineNumber = VB'(ln);
        chunkCount = 7'(cnt);
        startLine = 1'b1;
        @(posedge clk); #1;
        startLine = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input int budget, input string tag);
        int i = 0;
        while (done_cnt == start_cnt && i < budget) begin
            @(posedge clk);
            i++;
        end
        check(tag, 32'(done_cnt - start_cnt), 1);
    endtask

    // Directed steps followed by randomized lines
    initial begin
        int d0, ln, cnt, i;
        reset = 1'b1; startLine = 1'b0; lineNumber = '0; chunkCount = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Basic line: 3 chunks of line 5, pixel value equals x
        salt = '0;
        d0 = done_cnt;
        start_line(5, 3);
        @(negedge clk);
        check("t1_busy", 32'(busy), 1);
        wait_done(d0, 2000, "t1_done");
        check("t1_first_req", 32'(first_req), 32'h140);
        check("t1_reqs", reqs_seen, 3);
        check("t1_writes", writes_seen, 96);
        check("t1_last_addr", 32'(done_addr), 95);
        @(negedge clk);
        check("t1_busy_after", 32'(busy), 0);

        // Credit limit with the response FIFO held empty
        hold_empty = 1;
        d0 = done_cnt;
        start_line(100, 4);
        repeat (30) @(posedge clk);
        check("t2_held_reqs", reqs_seen, 2);
        hold_empty = 0;
        wait_done(d0, 3000, "t2_done");
        check("t2_req3_gap", 32'(req3_cyc - w32_cyc), 1);
        check("t2_reqs", reqs_seen, 4);
        check("t2_writes", writes_seen, 128);

        // Request FIFO full for the first cycles of the line
        hold_full = 1;
        d0 = done_cnt;
        start_line(200, 2);
        repeat (9) @(posedge clk);
        check("t3_no_req_while_full", reqs_seen, 0);
        hold_full = 0;
        wait_done(d0, 2000, "t3_done");
        check("t3_reqs", reqs_seen, 2);
        check("t3_writes", writes_seen, 64);

        // Response FIFO empty every other cycle
        toggle_empty = 1;
        salt = 16'($urandom);
        d0 = done_cnt;
        start_line(int'($urandom_range(0, 2047)), 2);
        wait_done(d0, 2000, "t4_done");
        check("t4_writes", writes_seen, 64);
        check("t4_last_addr", 32'(done_addr), 63);
        toggle_empty = 0;

        // Zero-chunk line
        d0 = done_cnt;
        start_line(9, 0);
        @(negedge clk);
        check("t5_zero_done", 32'(lineDone), 1);
        check("t5_zero_busy", 32'(busy), 0);
        @(negedge clk);
        check("t5_zero_done_drop", 32'(lineDone), 0);
        @(posedge clk);
        check("t5_zero_done_cnt", 32'(done_cnt - d0), 1);
        check("t5_zero_reqs", reqs_seen, 0);
        check("t5_zero_writes", writes_seen, 0);

        // Full-width line with random response stalls
        rnd_empty = 1;
        salt = 16'($urandom);
        d0 = done_cnt;
        start_line(int'($urandom_range(0, 2047)), 64);
        wait_done(d0, 9000, "t5_full_done");
        check("t5_full_last_addr", 32'(done_addr), 2047);
        check("t5_full_reqs", reqs_seen, 64);
        check("t5_full_writes", writes_seen, 2048);
        rnd_empty = 0;

        // Reset mid-line, then restart
        salt = 16'($urandom);
        start_line(33, 3);
        i = 0;
        while (writes_seen < 40 && i < 2000) begin
            @(posedge clk);
            i++;
        end
        check("t6_reached40", 32'(writes_seen >= 40), 1);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_idle("t6_abort");
        d0 = done_cnt;
        start_line(7, 1);
        wait_done(d0, 1000, "t6_restart_done");
        check("t6_first_req", 32'(first_req), 32'h1C0);
        check("t6_writes", writes_seen, 32);
        check("t6_last_addr", 32'(done_addr), 31);

        // Random lines with random stalls on both FIFOs
        rnd_empty = 1;
        rnd_full = 1;
        for (int k = 0; k < 4; k++) begin
            ln = int'($urandom_range(0, 2047));
            cnt = int'($urandom_range(1, 6));
            salt = 16'($urandom);
            d0 = done_cnt;
            start_line(ln, cnt);
            wait_done(d0, 2000, "t7_done");
            check("t7_reqs", reqs_seen, cnt);
            check("t7_writes", writes_seen, cnt * 32);
        end
        rnd_empty = 0;
        rnd_full = 0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
